// File: rtl/vmem_port_arbiter.sv
// Arbitrates the shared DDR MCB command path between the display read engine
// and the two capture writers: one line burst per grant, reads first, writers round-robin.
module vmem_port_arbiter #(
  parameter int TIMEOUT = 4095,
  parameter int PEND_W  = 3
) (
  input  logic              i_pclk,
  input  logic              i_rst,
  input  logic              i_frame_clr,
  input  logic              i_rd_req,
  input  logic [1:0]        i_wr_req,
  input  logic              i_rd_done,
  input  logic [1:0]        i_wr_done,
  output logic              o_rd_en,
  output logic [1:0]        o_wr_en,
  output logic [1:0]        o_arb_state,
  output logic              o_busy,
  output logic [PEND_W-1:0] o_rd_pend,
  output logic              o_ovf_err,
  output logic              o_tmo_err,
  output logic [15:0]       o_grant_cnt
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_GRANT_RD = 2'd1,
    S_GRANT_WR = 2'd2,
    S_RELEASE  = 2'd3
  } state_t;

  // Owner codes are chosen to equal the arb_state code of that owner.
  localparam logic [1:0]        OWN_RD    = 2'b00;
  localparam logic [1:0]        OWN_W0    = 2'b01;
  localparam logic [1:0]        OWN_W1    = 2'b10;
  localparam logic [1:0]        ARB_NONE  = 2'b11;
  localparam logic [PEND_W-1:0] PEND_ZERO = {PEND_W{1'b0}};
  localparam logic [PEND_W-1:0] PEND_ONE  = {{(PEND_W-1){1'b0}}, 1'b1};
  localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};
  localparam logic [11:0]       WDOG_LAST = 12'(TIMEOUT - 1);

  state_t            r_state, w_state_nxt;
  logic [1:0]        r_owner, w_owner_nxt;
  logic              r_rr_ptr, w_rr_ptr_nxt;
  logic [11:0]       r_wdog;
  logic [PEND_W-1:0] r_rd_pend, w_pend_nxt;
  logic              r_ovf_err, r_tmo_err, w_ovf_set;
  logic [15:0]       r_grant_cnt;
  logic              r_rd_en, r_busy;
  logic [1:0]        r_wr_en, r_arb_state;
  logic              w_rd_en_nxt, w_busy_nxt;
  logic [1:0]        w_wr_en_nxt, w_arb_nxt;
  logic              w_owner_done, w_granted, w_done_evt, w_tmo_evt, w_rd_cmpl;

  always_comb begin
    case (r_owner)
      OWN_RD:  w_owner_done = i_rd_done;
      OWN_W0:  w_owner_done = i_wr_done[0];
      OWN_W1:  w_owner_done = i_wr_done[1];
      default: w_owner_done = 1'b0;
    endcase
  end

  assign w_granted  = (r_state == S_GRANT_RD) || (r_state == S_GRANT_WR);
  assign w_done_evt = w_granted && w_owner_done;
  assign w_tmo_evt  = w_granted && !w_owner_done && (r_wdog == WDOG_LAST);
  assign w_rd_cmpl  = w_done_evt && (r_state == S_GRANT_RD);

  // A frame clear overrides both a request and a completion in the same cycle.
  always_comb begin
    w_pend_nxt = r_rd_pend;
    w_ovf_set  = 1'b0;
    if (i_frame_clr) begin
      w_pend_nxt = i_rd_req ? PEND_ONE : PEND_ZERO;
    end else if (i_rd_req && !w_rd_cmpl) begin
      if (r_rd_pend == PEND_MAX) w_ovf_set = 1'b1;
      else                       w_pend_nxt = r_rd_pend + PEND_ONE;
    end else if (!i_rd_req && w_rd_cmpl) begin
      if (r_rd_pend != PEND_ZERO) w_pend_nxt = r_rd_pend - PEND_ONE;
      else                        w_pend_nxt = PEND_ZERO;
    end else begin
      w_pend_nxt = r_rd_pend;
    end
  end

  always_ff @(posedge i_pclk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_owner  <= OWN_RD;
      r_rr_ptr <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_owner  <= w_owner_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

  // IDLE looks at the updated pending count so a request is granted the next cycle.
  always_comb begin
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_rr_ptr_nxt = r_rr_ptr;
    case (r_state)
      S_IDLE: begin
        if (w_pend_nxt != PEND_ZERO) begin
          w_state_nxt = S_GRANT_RD;
          w_owner_nxt = OWN_RD;
        end else if (i_wr_req == 2'b01) begin
          w_state_nxt = S_GRANT_WR;
          w_owner_nxt = OWN_W0;
        end else if (i_wr_req == 2'b10) begin
          w_state_nxt = S_GRANT_WR;
          w_owner_nxt = OWN_W1;
        end else if (i_wr_req == 2'b11) begin
          w_state_nxt  = S_GRANT_WR;
          w_owner_nxt  = r_rr_ptr ? OWN_W1 : OWN_W0;
          w_rr_ptr_nxt = ~r_rr_ptr;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_GRANT_RD, S_GRANT_WR: begin
        if (w_done_evt || w_tmo_evt) w_state_nxt = S_RELEASE;
        else                         w_state_nxt = r_state;
      end
      S_RELEASE: begin
        if (!w_owner_done) w_state_nxt = S_IDLE;
        else               w_state_nxt = S_RELEASE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy_nxt  = (w_state_nxt == S_GRANT_RD) || (w_state_nxt == S_GRANT_WR);
    w_rd_en_nxt = (w_state_nxt == S_GRANT_RD);
    w_arb_nxt   = w_busy_nxt ? w_owner_nxt : ARB_NONE;
    if (w_state_nxt == S_GRANT_WR) w_wr_en_nxt = (w_owner_nxt == OWN_W1) ? 2'b10 : 2'b01;
    else                           w_wr_en_nxt = 2'b00;
  end

  always_ff @(posedge i_pclk) begin
    if (i_rst) begin
      r_rd_en     <= 1'b0;
      r_wr_en     <= 2'b00;
      r_arb_state <= ARB_NONE;
      r_busy      <= 1'b0;
    end else begin
      r_rd_en     <= w_rd_en_nxt;
      r_wr_en     <= w_wr_en_nxt;
      r_arb_state <= w_arb_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  // A watchdog firing in the same cycle as frame_clr leaves tmo_err set.
  always_ff @(posedge i_pclk) begin
    if (i_rst) begin
      r_wdog      <= 12'd0;
      r_rd_pend   <= PEND_ZERO;
      r_ovf_err   <= 1'b0;
      r_tmo_err   <= 1'b0;
      r_grant_cnt <= 16'd0;
    end else begin
      r_wdog      <= (w_granted && (w_state_nxt != S_RELEASE)) ? r_wdog + 12'd1 : 12'd0;
      r_rd_pend   <= w_pend_nxt;
      r_ovf_err   <= w_ovf_set ? 1'b1 : (i_frame_clr ? 1'b0 : r_ovf_err);
      r_tmo_err   <= w_tmo_evt ? 1'b1 : (i_frame_clr ? 1'b0 : r_tmo_err);
      r_grant_cnt <= w_done_evt ? r_grant_cnt + 16'd1 : r_grant_cnt;
    end
  end

  assign o_rd_en     = r_rd_en;
  assign o_wr_en     = r_wr_en;
  assign o_arb_state = r_arb_state;
  assign o_busy      = r_busy;
  assign o_rd_pend   = r_rd_pend;
  assign o_ovf_err   = r_ovf_err;
  assign o_tmo_err   = r_tmo_err;
  assign o_grant_cnt = r_grant_cnt;

endmodule

// File: tb/tb_vmem_port_arbiter.sv
// Bench for vmem_port_arbiter: directed scenarios plus random traffic compared
// against a transaction-level model of owner, pending count and flags.
module tb_vmem_port_arbiter;

  localparam int TIMEOUT = 4095;
  localparam int PEND_W  = 3;
  localparam int PMAX    = (1 << PEND_W) - 1;

  logic              pclk = 1'b0;
  logic              rst, frame_clr, rd_req, rd_done;
  logic [1:0]        wr_req, wr_done;
  logic              rd_en, busy, ovf_err, tmo_err;
  logic [1:0]        wr_en, arb_state;
  logic [PEND_W-1:0] rd_pend;
  logic [15:0]       grant_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: -1 = nobody owns the port, else 0 read / 1 writer0 / 2 writer1.
  int m_own, m_rel_own, m_age, m_pend, m_cnt;
  bit m_rel, m_ovf, m_tmo, m_rr;

  vmem_port_arbiter #(.TIMEOUT(TIMEOUT), .PEND_W(PEND_W)) dut (
    .i_pclk(pclk), .i_rst(rst), .i_frame_clr(frame_clr), .i_rd_req(rd_req),
    .i_wr_req(wr_req), .i_rd_done(rd_done), .i_wr_done(wr_done),
    .o_rd_en(rd_en), .o_wr_en(wr_en), .o_arb_state(arb_state), .o_busy(busy),
    .o_rd_pend(rd_pend), .o_ovf_err(ovf_err), .o_tmo_err(tmo_err), .o_grant_cnt(grant_cnt)
  );

  always #5 pclk = ~pclk;

  function automatic bit odone(input int o);
    return (o == 0) ? rd_done : wr_done[o-1];
  endfunction

  task automatic model_next();
    int  p;
    bit  cmpl;
    if (rst) begin
      m_own = -1; m_rel = 0; m_rel_own = 0; m_age = 0; m_pend = 0;
      m_ovf = 0; m_tmo = 0; m_cnt = 0; m_rr = 0;
      return;
    end
    cmpl = (m_own == 0) && rd_done;
    p = m_pend + (rd_req ? 1 : 0) - (cmpl ? 1 : 0);
    if (frame_clr) begin
      p = rd_req ? 1 : 0; m_ovf = 0; m_tmo = 0;
    end else if (p > PMAX) begin
      p = PMAX; m_ovf = 1;
    end
    if (p < 0) p = 0;
    if (m_own >= 0) begin
      if (odone(m_own)) begin
        m_cnt = (m_cnt + 1) % 65536; m_rel = 1; m_rel_own = m_own; m_own = -1;
      end else if (m_age == TIMEOUT - 1) begin
        m_tmo = 1; m_rel = 1; m_rel_own = m_own; m_own = -1;
      end else begin
        m_age++;
      end
    end else if (m_rel) begin
      if (!odone(m_rel_own)) m_rel = 0;
    end else begin
      m_age = 0;
      if (p > 0) m_own = 0;
      else if (wr_req == 2'b11) begin m_own = m_rr ? 2 : 1; m_rr = !m_rr; end
      else if (wr_req == 2'b01) m_own = 1;
      else if (wr_req == 2'b10) m_own = 2;
    end
    m_pend = p;
  endtask

  task automatic tick();
    model_next();
    @(posedge pclk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; frame_clr = 1'b0; rd_req = 1'b0; wr_req = 2'b00;
    rd_done = 1'b0; wr_done = 2'b00;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (busy) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; frame_clr = 1'b0; rd_req = 1'b1; wr_req = 2'b11;
    rd_done = 1'b0; wr_done = 2'b00;
    tick(); tick();
    n_checks++; if ({rd_en, wr_en, arb_state, busy} !== 6'b0_00_11_0)
      $display("FAIL reset_ctrl: got %b want 000110", {rd_en, wr_en, arb_state, busy}); else n_pass++;
    n_checks++; if (rd_pend !== 3'd0) $display("FAIL reset_pend: got %0d want 0", rd_pend); else n_pass++;
    n_checks++; if ({ovf_err, tmo_err} !== 2'b00) $display("FAIL reset_err: got %b want 00", {ovf_err, tmo_err}); else n_pass++;
    n_checks++; if (grant_cnt !== 16'd0) $display("FAIL reset_cnt: got %0d want 0", grant_cnt); else n_pass++;
    rst = 1'b0; rd_req = 1'b0; wr_req = 2'b00;
  endtask

  task automatic test_read_grant();
    do_reset();
    repeat (8) tick();
    rd_req = 1'b1; tick(); rd_req = 1'b0;
    n_checks++; if ({rd_en, wr_en, arb_state} !== 5'b1_00_00)
      $display("FAIL rd_grant: got %b want 10000", {rd_en, wr_en, arb_state}); else n_pass++;
    n_checks++; if (rd_pend !== 3'd1) $display("FAIL rd_pend_up: got %0d want 1", rd_pend); else n_pass++;
    repeat (8) tick();
    n_checks++; if ({rd_en, arb_state} !== 3'b1_00) $display("FAIL rd_hold: got %b want 100", {rd_en, arb_state}); else n_pass++;
    rd_done = 1'b1; tick();
    n_checks++; if ({rd_en, arb_state, rd_pend, grant_cnt} !== {1'b0, 2'b11, 3'd0, 16'd1})
      $display("FAIL rd_complete: got en=%b arb=%b pend=%0d cnt=%0d want 0 11 0 1", rd_en, arb_state, rd_pend, grant_cnt); else n_pass++;
    repeat (3) tick();
    n_checks++; if ({busy, arb_state, grant_cnt} !== {1'b0, 2'b11, 16'd1})
      $display("FAIL rd_release_hold: got busy=%b arb=%b cnt=%0d want 0 11 1", busy, arb_state, grant_cnt); else n_pass++;
    rd_done = 1'b0; tick(); tick();
    n_checks++; if ({busy, arb_state} !== 3'b0_11) $display("FAIL rd_idle: got %b want 011", {busy, arb_state}); else n_pass++;
  endtask

  task automatic test_round_robin();
    bit ok;
    logic [1:0] exp_code;
    do_reset();
    wr_req = 2'b11;
    for (int g = 0; g < 6; g++) begin
      exp_code = (g % 2 == 0) ? 2'b01 : 2'b10;
      wait_grant(ok);
      n_checks++; if (!ok) $display("FAIL rr_wait: no grant %0d within 20 cycles", g); else n_pass++;
      n_checks++; if ({rd_en, wr_en, arb_state} !== {1'b0, exp_code, exp_code})
        $display("FAIL rr_owner: grant %0d got en=%b%b arb=%b want wr_en=%b", g, rd_en, wr_en, arb_state, exp_code); else n_pass++;
      tick(); tick();
      wr_done = exp_code; tick();
      n_checks++; if ({busy, wr_en, arb_state} !== 5'b0_00_11)
        $display("FAIL rr_drop: grant %0d got %b want 00011", g, {busy, wr_en, arb_state}); else n_pass++;
      repeat (3) tick();
      wr_done = 2'b00; tick();
      n_checks++; if (busy !== 1'b0) $display("FAIL rr_gap: grant %0d got busy %b want 0", g, busy); else n_pass++;
    end
    wr_req = 2'b00;
    tick();
  endtask

  task automatic test_read_priority();
    bit ok;
    do_reset();
    wr_req = 2'b01;
    wait_grant(ok);
    n_checks++; if (!ok || arb_state !== 2'b01) $display("FAIL prio_w0: got arb %b want 01", arb_state); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      rd_req = 1'b1; tick(); rd_req = 1'b0; tick();
    end
    n_checks++; if ({arb_state, rd_pend} !== {2'b01, 3'd3})
      $display("FAIL prio_pend3: got arb=%b pend=%0d want 01 3", arb_state, rd_pend); else n_pass++;
    wr_done = 2'b01; tick(); wr_done = 2'b00; tick();
    for (int k = 0; k < 3; k++) begin
      wait_grant(ok);
      n_checks++; if (!ok || {rd_en, arb_state} !== 3'b1_00)
        $display("FAIL prio_rd: read %0d got en=%b arb=%b want 1 00", k, rd_en, arb_state); else n_pass++;
      tick(); rd_done = 1'b1; tick();
      n_checks++; if (rd_pend !== 3'(2 - k)) $display("FAIL prio_pend: read %0d got %0d want %0d", k, rd_pend, 2 - k); else n_pass++;
      rd_done = 1'b0; tick();
    end
    wait_grant(ok);
    n_checks++; if (!ok || {wr_en, arb_state} !== 4'b01_01)
      $display("FAIL prio_resume: got wr_en=%b arb=%b want 01 01", wr_en, arb_state); else n_pass++;
    wr_done = 2'b01; tick(); wr_req = 2'b00; wr_done = 2'b00; tick(); tick();
  endtask

  task automatic test_overflow();
    do_reset();
    rd_req = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      n_checks++; if (rd_pend !== 3'((k + 1 > PMAX) ? PMAX : k + 1))
        $display("FAIL ovf_pend: pulse %0d got %0d", k, rd_pend); else n_pass++;
    end
    rd_req = 1'b0;
    n_checks++; if ({ovf_err, rd_en} !== 2'b11) $display("FAIL ovf_flag: got ovf=%b en=%b want 1 1", ovf_err, rd_en); else n_pass++;
    frame_clr = 1'b1; tick(); frame_clr = 1'b0;
    n_checks++; if ({rd_pend, ovf_err, rd_en} !== {3'd0, 1'b0, 1'b1})
      $display("FAIL ovf_clr: got pend=%0d ovf=%b en=%b want 0 0 1", rd_pend, ovf_err, rd_en); else n_pass++;
    rd_done = 1'b1; tick(); rd_done = 1'b0;
    n_checks++; if ({rd_pend, grant_cnt, rd_en} !== {3'd0, 16'd1, 1'b0})
      $display("FAIL ovf_no_underflow: got pend=%0d cnt=%0d en=%b want 0 1 0", rd_pend, grant_cnt, rd_en); else n_pass++;
    tick(); tick();
    n_checks++; if (busy !== 1'b0) $display("FAIL ovf_idle: got busy %b want 0", busy); else n_pass++;
  endtask

  task automatic test_timeout();
    int cnt;
    do_reset();
    wr_req = 2'b10; tick(); wr_req = 2'b00;
    n_checks++; if ({wr_en, arb_state} !== 4'b10_10) $display("FAIL tmo_grant: got %b want 1010", {wr_en, arb_state}); else n_pass++;
    cnt = 0;
    while (wr_en == 2'b10 && cnt < 5000) begin cnt++; tick(); end
    n_checks++; if (cnt !== TIMEOUT) $display("FAIL tmo_len: got %0d cycles want %0d", cnt, TIMEOUT); else n_pass++;
    n_checks++; if ({tmo_err, arb_state, grant_cnt} !== {1'b1, 2'b11, 16'd0})
      $display("FAIL tmo_flags: got tmo=%b arb=%b cnt=%0d want 1 11 0", tmo_err, arb_state, grant_cnt); else n_pass++;
    tick(); tick();
    n_checks++; if ({busy, arb_state} !== 3'b0_11) $display("FAIL tmo_idle: got %b want 011", {busy, arb_state}); else n_pass++;
    frame_clr = 1'b1; tick(); frame_clr = 1'b0;
    n_checks++; if (tmo_err !== 1'b0) $display("FAIL tmo_clr: got %b want 0", tmo_err); else n_pass++;
  endtask

  task automatic test_same_cycle();
    do_reset();
    rd_req = 1'b1; tick(); tick();
    rd_done = 1'b1; tick();
    rd_req = 1'b0; rd_done = 1'b0;
    n_checks++; if ({rd_pend, grant_cnt, rd_en} !== {3'd2, 16'd1, 1'b0})
      $display("FAIL same_cycle: got pend=%0d cnt=%0d en=%b want 2 1 0", rd_pend, grant_cnt, rd_en); else n_pass++;
    tick(); tick();
    n_checks++; if (rd_en !== 1'b1) $display("FAIL regrant: got en %b want 1", rd_en); else n_pass++;
    rst = 1'b1; rd_req = 1'b1; wr_req = 2'b11; tick();
    n_checks++; if ({rd_en, wr_en, arb_state, busy, rd_pend, ovf_err, tmo_err, grant_cnt} !== {6'b0_00_11_0, 3'd0, 2'b00, 16'd0})
      $display("FAIL rst_mid_grant: got en=%b%b arb=%b pend=%0d cnt=%0d", rd_en, wr_en, arb_state, rd_pend, grant_cnt); else n_pass++;
    rst = 1'b0; rd_req = 1'b0; wr_req = 2'b00; tick();
  endtask

  task automatic test_random();
    logic [1:0] e_wr;
    logic [1:0] e_arb;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 599) == 0);
      frame_clr = ($urandom_range(0, 79) == 0);
      rd_req    = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 7) == 0) wr_req = 2'($urandom);
      rd_done    = ($urandom_range(0, 2) == 0);
      wr_done[0] = ($urandom_range(0, 2) == 0);
      wr_done[1] = ($urandom_range(0, 2) == 0);
      tick();
      e_wr  = (m_own == 1) ? 2'b01 : (m_own == 2) ? 2'b10 : 2'b00;
      e_arb = (m_own < 0) ? 2'b11 : 2'(m_own);
      n_checks++;
      if ({rd_en, wr_en, arb_state, busy, rd_pend, ovf_err, tmo_err, grant_cnt} !==
          {(m_own == 0), e_wr, e_arb, (m_own >= 0), 3'(m_pend), m_ovf, m_tmo, 16'(m_cnt)})
        $display("FAIL random c%0d: got en=%b%b arb=%b pend=%0d ovf=%b tmo=%b cnt=%0d want en=%b%b arb=%b pend=%0d ovf=%b tmo=%b cnt=%0d",
                 c, rd_en, wr_en, arb_state, rd_pend, ovf_err, tmo_err, grant_cnt,
                 (m_own == 0), e_wr, e_arb, m_pend, m_ovf, m_tmo, m_cnt);
      else n_pass++;
    end
    rst = 1'b0; frame_clr = 1'b0; rd_req = 1'b0; wr_req = 2'b00; rd_done = 1'b0; wr_done = 2'b00;
  endtask

  initial begin
    test_reset();
    test_read_grant();
    test_round_robin();
    test_read_priority();
    test_overflow();
    test_timeout();
    test_same_cycle();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vmem_port_arbiter.md
Name: vmem_port_arbiter

Overview:
Arbitrates the single DDR MCB command path between the display read engine and two capture write engines (left/right eye) on a per-line-burst basis. Each client receives a level enable and answers with a stretched done signal, one line transfer per grant. The block drives the shared 2-bit arb_state bus that every engine checks before issuing MCB commands. Display reads take priority; the two writers share the remaining slots round-robin. A watchdog recovers a hung grant.

Parameters:
TIMEOUT, 4095, grant watchdog limit in pclk cycles (12-bit counter).
PEND_W, 3, width of the saturating pending-read-line counter.

Ports:
pclk  in  1  clock
rst  in  1  synchronous, active-high reset
frame_clr  in  1  one-cycle pulse at display frame start; clears pending reads and error flags
rd_req  in  1  one-cycle pulse: display needs one more line fetched
wr_req  in  2  level per writer: capture FIFO holds at least one line
rd_done  in  1  read engine completion, high for at least 1 cycle after the line finishes
wr_done  in  2  writer completion, same rule as rd_done
rd_en  out  1  grant to read engine
wr_en  out  2  grant to writers, at most one bit high
arb_state  out  2  owner code: 00 = read, 01 = writer0, 10 = writer1, 11 = none
busy  out  1  high in any grant state
rd_pend  out  PEND_W  current pending-read count
ovf_err  out  1  sticky: rd_req arrived while rd_pend was saturated
tmo_err  out  1  sticky: watchdog fired
grant_cnt  out  16  wrapping count of completed grants (debug)

Behaviour:
- Reset values: state IDLE, rd_en = 0, wr_en = 00, arb_state = 11, busy = 0, rd_pend = 0, ovf_err = 0, tmo_err = 0, grant_cnt = 0, rr_ptr = 0, wdog = 0.
- All outputs are registered.
- States:
  - IDLE, GRANT_RD, GRANT_WR, RELEASE.
- IDLE, checked in priority order:
  - rd_pend != 0: go to GRANT_RD, rd_en = 1, arb_state = 00.
  - Else, if only one wr_req bit is set: grant that writer.
  - Else, if both are set: grant writer rr_ptr, then toggle rr_ptr. Set wr_en[i] = 1 and arb_state = i+1.
  - Else: stay in IDLE.
  - Latency: request seen in cycle N, enable high in cycle N+1.
- GRANT_RD / GRANT_WR:
  - The enable and arb_state hold steady.
  - wdog increments every cycle in these states.
  - When the owner's done is sampled high: drop the enable, go to RELEASE, increment grant_cnt. For GRANT_RD, also decrement rd_pend.
  - When wdog = TIMEOUT-1 without done: drop the enable, set tmo_err, go to RELEASE. rd_pend is not decremented and grant_cnt is not incremented.
- RELEASE:
  - arb_state = 11, all enables low, wdog cleared.
  - Wait until the previous owner's done is low, so a stretched done is never read as a second completion.
  - Then go to IDLE. This gives a minimum 1-cycle gap between grants.
- rd_pend arithmetic:
  - rd_req alone: +1, saturating at 2^PEND_W-1.
  - Read completion alone: -1.
  - rd_req and read completion in the same cycle: unchanged.
  - rd_req while saturated with no completion: count held, ovf_err set.
- frame_clr:
  - Takes effect the next cycle: rd_pend = 0, ovf_err = 0, tmo_err = 0.
  - Does not abort an active grant; it completes normally.
  - If a read completion coincides with frame_clr, rd_pend becomes 0, not -1.
  - If rd_req coincides with frame_clr, rd_pend becomes 1.
- Invariants:
  - rd_en and wr_en are one-hot-or-zero.
  - The enable is high if and only if arb_state != 11.
  - A grant never changes owner mid-transfer.
- Writer request dropped during its own grant: the grant continues until done or timeout.
- Reset mid-grant: everything returns to reset values on the next edge and all enables drop immediately.

Test Plan:
- Reset, then rd_req pulse at cycle 10 → rd_en = 1 and arb_state = 00 at cycle 11. Assert rd_done cycles 20-23 → rd_en = 0 at cycle 21, rd_pend = 0, grant_cnt = 1, arb_state = 11 until rd_done falls, then IDLE.
- Hold wr_req = 11 with no reads, each done 4 cycles long → grants alternate writer0, writer1, writer0, …, arb_state 01/10/01. Each enable stays low for at least 1 cycle between grants.
- Writer0 granted and 3 rd_req pulses arrive during it → the next three grants are read. rd_pend steps 3, 2, 1, 0. Writers resume afterwards.
- 8 rd_req pulses with no grant completing (PEND_W = 3) → rd_pend = 7, ovf_err = 1. A frame_clr pulse then gives rd_pend = 0 and ovf_err = 0.
- Grant writer1 and never assert done → wr_en drops after 4095 cycles, tmo_err = 1, grant_cnt unchanged, arbiter returns to IDLE.
- rd_req pulse in the same cycle rd_done completes a read → rd_pend unchanged. Assert rst mid-grant → all outputs at reset values the next cycle.
